// File: rtl/memory_request_unit.sv
// rtl/memory_request_unit.sv - arbitrates fetch and data requests onto one single-port RAM (optional MEMREQ_IFETCH_BUFFER_EN fetch buffer)
module memory_request_unit #(
    parameter int          ADDR_W         = 16,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ABORT_WORD     = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              iren,
    input  logic [31:0]       imemaddr,
    input  logic              dren,
    input  logic              dwen,
    input  logic [31:0]       dmemaddr,
    input  logic [31:0]       dmemstore,
    output logic [31:0]       imemload,
    output logic              i_ready,
    output logic [31:0]       dmemload,
    output logic              d_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_store,
    output logic              ram_ren,
    output logic              ram_wen,
    input  logic [31:0]       ram_load,
    input  logic              ram_ack,
    output logic              misalign,
    output logic              timeout
);

    typedef enum logic [2:0] {IDLE, DATA, FETCH, DONE_D, DONE_I} state_t;

    // Counter only has to reach TIMEOUT_CYCLES-1: the abort fires on the cycle it is seen there.
    localparam int               CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_write;
    logic             mis_q;

    logic [ADDR_W-1:0] dword;
    logic [ADDR_W-1:0] iword;
    logic              unused_addr_bits;

    assign dword = dmemaddr[ADDR_W+1:2];
    assign iword = imemaddr[ADDR_W+1:2];
    assign unused_addr_bits = &{1'b0, dmemaddr[31:ADDR_W+2], imemaddr[31:ADDR_W+2]};

`ifdef MEMREQ_IFETCH_BUFFER_EN
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       buf_data;
`endif

    // Request FSM: arbitration, held RAM command, timeout abort and registered result pulses.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            cnt       <= '0;
            is_write  <= 1'b0;
            mis_q     <= 1'b0;
            imemload  <= '0;
            i_ready   <= 1'b0;
            dmemload  <= '0;
            d_ready   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            misalign  <= 1'b0;
            timeout   <= 1'b0;
`ifdef MEMREQ_IFETCH_BUFFER_EN
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    i_ready  <= 1'b0;
                    d_ready  <= 1'b0;
                    misalign <= 1'b0;
                    timeout  <= 1'b0;
                    cnt      <= '0;
                    if (dren || dwen) begin
                        // A simultaneous read and write request is a write.
                        ram_addr  <= dword;
                        ram_store <= dmemstore;
                        ram_wen   <= dwen;
                        ram_ren   <= !dwen;
                        is_write  <= dwen;
                        mis_q     <= |dmemaddr[1:0];
                        state     <= DATA;
                    end else if (iren) begin
                        mis_q <= |imemaddr[1:0];
`ifdef MEMREQ_IFETCH_BUFFER_EN
                        if (buf_valid && (buf_addr == iword)) begin
                            imemload <= buf_data;
                            i_ready  <= 1'b1;
                            misalign <= |imemaddr[1:0];
                            state    <= DONE_I;
                        end else begin
                            ram_addr <= iword;
                            ram_ren  <= 1'b1;
                            state    <= FETCH;
                        end
`else
                        ram_addr <= iword;
                        ram_ren  <= 1'b1;
                        state    <= FETCH;
`endif
                    end
                end
                DATA, FETCH: begin
                    if (ram_ack) begin
                        ram_ren  <= 1'b0;
                        ram_wen  <= 1'b0;
                        misalign <= mis_q;
                        if (state == FETCH) begin
                            imemload <= ram_load;
                            i_ready  <= 1'b1;
                            state    <= DONE_I;
`ifdef MEMREQ_IFETCH_BUFFER_EN
                            buf_valid <= 1'b1;
                            buf_addr  <= ram_addr;
                            buf_data  <= ram_load;
`endif
                        end else begin
                            if (!is_write) begin
                                dmemload <= ram_load;
                            end
                            d_ready <= 1'b1;
                            state   <= DONE_D;
`ifdef MEMREQ_IFETCH_BUFFER_EN
                            if (is_write && (buf_addr == ram_addr)) begin
                                buf_valid <= 1'b0;
                            end
`endif
                        end
                    end else if (TMO_EN && (cnt == CNT_LAST)) begin
                        // Abort: an unacknowledged write never reaches RAM, a read returns ABORT_WORD.
                        ram_ren  <= 1'b0;
                        ram_wen  <= 1'b0;
                        misalign <= mis_q;
                        timeout  <= 1'b1;
`ifdef MEMREQ_IFETCH_BUFFER_EN
                        buf_valid <= 1'b0;
`endif
                        if (state == FETCH) begin
                            imemload <= ABORT_WORD;
                            i_ready  <= 1'b1;
                            state    <= DONE_I;
                        end else begin
                            if (!is_write) begin
                                dmemload <= ABORT_WORD;
                            end
                            d_ready <= 1'b1;
                            state   <= DONE_D;
                        end
                    end else if (TMO_EN && (cnt != CNT_MAX)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE_D, DONE_I: begin
                    i_ready  <= 1'b0;
                    d_ready  <= 1'b0;
                    misalign <= 1'b0;
                    timeout  <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_request_unit.sv
// tb/tb_memory_request_unit.sv - randomized self-checking bench for memory_request_unit
module tb_memory_request_unit;

    localparam int          TMO   = 4;
    localparam logic [31:0] ABORT = 32'hDEADBEEF;

    logic        clk;
    logic        nRST;
    logic        iren;
    logic [31:0] imemaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic [31:0] imemload;
    logic        i_ready;
    logic [31:0] dmemload;
    logic        d_ready;
    logic [15:0] ram_addr;
    logic [31:0] ram_store;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_load;
    logic        ram_ack;
    logic        misalign;
    logic        timeout;

    memory_request_unit #(
        .ADDR_W(16),
        .TIMEOUT_CYCLES(TMO),
        .ABORT_WORD(ABORT)
    ) dut (
        .clk(clk),
        .nRST(nRST),
        .iren(iren),
        .imemaddr(imemaddr),
        .dren(dren),
        .dwen(dwen),
        .dmemaddr(dmemaddr),
        .dmemstore(dmemstore),
        .imemload(imemload),
        .i_ready(i_ready),
        .dmemload(dmemload),
        .d_ready(d_ready),
        .ram_addr(ram_addr),
        .ram_store(ram_store),
        .ram_ren(ram_ren),
        .ram_wen(ram_wen),
        .ram_load(ram_load),
        .ram_ack(ram_ack),
        .misalign(misalign),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: RAM contents, last returned words, fetch buffer image.
    logic [31:0] mem [int];
    logic [31:0] exp_dload = '0;
    logic [31:0] exp_iload = '0;
    bit          bv        = 1'b0;
    int          bword     = 0;
    logic [31:0] bdata     = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) & 32'h0000FFFF);
    endfunction

    function automatic logic [31:0] ram_word(input int w);
        if (mem.exists(w)) return mem[w];
        return 32'hA500_0000 + 32'(w);
    endfunction

    // Ready cycle: a spurious ack here must be ignored by the DUT.
    task automatic finish_access();
        ram_ack  = 1'($urandom_range(0, 1));
        ram_load = $urandom;
        @(negedge clk);
        ram_ack = 1'b0;
        check("idle_d_ready", 32'(d_ready), 32'd0);
        check("idle_i_ready", 32'(i_ready), 32'd0);
        check("idle_ren", 32'(ram_ren), 32'd0);
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of the next idle cycle.
    task automatic data_access(input bit wr, input logic [31:0] addr, input logic [31:0] st,
                               input int ack_delay, input bit keep_iren);
        int w;
        bit aborted;
        w       = word_of(addr);
        aborted = (ack_delay >= TMO);
        dwen      = wr;
        dren      = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        dmemaddr  = addr;
        dmemstore = st;
        iren      = keep_iren;
        @(negedge clk);
        dren = 1'b0;
        dwen = 1'b0;
        dmemaddr  = $urandom;
        dmemstore = $urandom;
        for (int k = 0; k < TMO; k++) begin
            check("d_cmd_ren", 32'(ram_ren), 32'(!wr));
            check("d_cmd_wen", 32'(ram_wen), 32'(wr));
            check("d_cmd_addr", 32'(ram_addr), 32'(w));
            if (wr) check("d_cmd_store", ram_store, st);
            check("d_wait_ready", 32'(d_ready | i_ready), 32'd0);
            if (k == ack_delay) begin
                ram_load = ram_word(w);
                ram_ack  = 1'b1;
            end else begin
                ram_load = $urandom;
            end
            @(negedge clk);
            ram_ack = 1'b0;
            if (k == ack_delay) break;
        end
        if (!wr) exp_dload = aborted ? ABORT : ram_word(w);
        if (aborted) bv = 1'b0;
        if (wr && !aborted) begin
            mem[w] = st;
            if (bv && bword == w) bv = 1'b0;
        end
        check("d_ready", 32'(d_ready), 32'd1);
        check("d_i_ready", 32'(i_ready), 32'd0);
        check("d_timeout", 32'(timeout), 32'(aborted));
        check("d_misalign", 32'(misalign), 32'(addr[1:0] != 2'b00));
        check("d_cmd_drop", 32'(ram_ren | ram_wen), 32'd0);
        check("dmemload", dmemload, exp_dload);
        check("d_imemload", imemload, exp_iload);
        finish_access();
    endtask

    task automatic fetch_access(input logic [31:0] addr, input int ack_delay);
        int w;
        bit aborted;
        w       = word_of(addr);
        aborted = (ack_delay >= TMO);
        iren     = 1'b1;
        imemaddr = addr;
        @(negedge clk);
        iren     = 1'b0;
        imemaddr = $urandom;
        if (bv && bword == w) begin
            check("hit_no_ren", 32'(ram_ren), 32'd0);
            check("hit_i_ready", 32'(i_ready), 32'd1);
            check("hit_misalign", 32'(misalign), 32'(addr[1:0] != 2'b00));
            check("hit_imemload", imemload, bdata);
            exp_iload = bdata;
        end else begin
            for (int k = 0; k < TMO; k++) begin
                check("i_cmd_ren", 32'(ram_ren), 32'd1);
                check("i_cmd_wen", 32'(ram_wen), 32'd0);
                check("i_cmd_addr", 32'(ram_addr), 32'(w));
                check("i_wait_ready", 32'(d_ready | i_ready), 32'd0);
                if (k == ack_delay) begin
                    ram_load = ram_word(w);
                    ram_ack  = 1'b1;
                end else begin
                    ram_load = $urandom;
                end
                @(negedge clk);
                ram_ack = 1'b0;
                if (k == ack_delay) break;
            end
            if (aborted) begin
                exp_iload = ABORT;
                bv        = 1'b0;
            end else begin
                exp_iload = ram_word(w);
`ifdef MEMREQ_IFETCH_BUFFER_EN
                bv    = 1'b1;
                bword = w;
                bdata = exp_iload;
`endif
            end
            check("i_ready", 32'(i_ready), 32'd1);
            check("i_timeout", 32'(timeout), 32'(aborted));
            check("i_misalign", 32'(misalign), 32'(addr[1:0] != 2'b00));
            check("i_cmd_drop", 32'(ram_ren | ram_wen), 32'd0);
            check("imemload", imemload, exp_iload);
        end
        check("i_d_ready", 32'(d_ready), 32'd0);
        check("i_dmemload", dmemload, exp_dload);
        finish_access();
    endtask

    initial begin
        nRST = 1'b0; iren = 1'b0; imemaddr = '0; dren = 1'b0; dwen = 1'b0;
        dmemaddr = '0; dmemstore = '0; ram_load = '0; ram_ack = 1'b0;
        @(negedge clk);
        check("rst_ren", 32'(ram_ren | ram_wen), 32'd0);
        check("rst_ready", 32'(i_ready | d_ready), 32'd0);
        check("rst_loads", imemload | dmemload, 32'd0);
        check("rst_flags", 32'(misalign | timeout), 32'd0);
        nRST = 1'b1;
        @(negedge clk);

        mem[16'h10] = 32'h00500093;
        fetch_access(32'h40, 2);
        check("fetch_0x40", imemload, 32'h00500093);
        data_access(1'b0, 32'h80, 32'h0, 0, 1'b1);
        fetch_access(32'h44, 1);
        data_access(1'b1, 32'h84, 32'hCAFEF00D, 3, 1'b0);
        data_access(1'b0, 32'h84, 32'h0, 0, 1'b0);
        check("readback_0x84", dmemload, 32'hCAFEF00D);
        data_access(1'b0, 32'h88, 32'h0, TMO, 1'b0);
        check("abort_dload", dmemload, ABORT);
        fetch_access(32'h42, TMO);
        fetch_access(32'h40, 0);
        fetch_access(32'h40, 1);
        data_access(1'b1, 32'h40, 32'h12345678, 0, 1'b0);
        fetch_access(32'h40, 0);
        check("refetch_0x40", imemload, 32'h12345678);
        data_access(1'b1, 32'h50, 32'h0BAD0BAD, TMO, 1'b0);
        data_access(1'b0, 32'h50, 32'h0, 1, 1'b0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            int dly;
            a   = 32'($urandom_range(0, 63));
            dly = $urandom_range(0, TMO);
            case ($urandom_range(0, 2))
                0: fetch_access(a, dly);
                1: data_access(1'b0, a, 32'h0, dly, 1'($urandom_range(0, 1)));
                default: data_access(1'b1, a, $urandom, dly, 1'($urandom_range(0, 1)));
            endcase
        end

        // Asynchronous reset in the middle of a fetch.
        iren     = 1'b1;
        imemaddr = 32'h60;
        @(negedge clk);
        check("mid_fetch_ren", 32'(ram_ren), 32'd1);
        #2 nRST = 1'b0;
        #1;
        check("arst_ren", 32'(ram_ren), 32'd0);
        check("arst_i_ready", 32'(i_ready), 32'd0);
        check("arst_imemload", imemload, 32'd0);
        check("arst_dmemload", dmemload, 32'd0);
        exp_iload = '0;
        exp_dload = '0;
        bv        = 1'b0;
        iren      = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(ram_ren | ram_wen), 32'd0);
        fetch_access(32'h60, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
